// File: rtl/nibble_packer.sv
// Pairs corrected Hamming(7,4) nibbles into bytes (low first) and queues them in a small FIFO.
// Optional NIBBLE_PACKER_ERR_TAG_EN adds a per-byte out_err tag carried through the FIFO.
module nibble_packer #(
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    input  logic [2:0]                    syndrome_in,
    input  logic [3:0]                    data_in,
    input  logic                          flush,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [7:0]                    out_byte,
`ifdef NIBBLE_PACKER_ERR_TAG_EN
    output logic [1:0]                    out_err,
`endif
    output logic [CNT_W-1:0]              err_count,
    output logic                          overflow,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam logic [LW-1:0] FULL_LVL = LW'(FIFO_DEPTH);

    typedef enum logic {LOW, HIGH} state_t;

    typedef struct packed {
`ifdef NIBBLE_PACKER_ERR_TAG_EN
        logic [1:0] err;
`endif
        logic [7:0] data;
    } entry_t;

    state_t          state, state_nxt;
    logic [3:0]      low_nib;
`ifdef NIBBLE_PACKER_ERR_TAG_EN
    logic            low_err;
`endif
    logic            syn_err;
    logic            push, pop, full, wr_en;
    entry_t          push_ent;
    entry_t          mem [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [LW-1:0]   level;

    assign syn_err = |syndrome_in;

    // ---------------- pairing FSM ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= LOW;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        push      = 1'b0;
        push_ent  = '0;
        case (state)
            LOW: if (in_valid) state_nxt = HIGH;
            HIGH: begin
                // A real nibble always wins over flush in the same cycle.
                if (in_valid) begin
                    push          = 1'b1;
                    push_ent.data = {data_in, low_nib};
`ifdef NIBBLE_PACKER_ERR_TAG_EN
                    push_ent.err  = {syn_err, low_err};
`endif
                    state_nxt     = LOW;
                end else if (flush) begin
                    push          = 1'b1;
                    push_ent.data = {4'h0, low_nib};
`ifdef NIBBLE_PACKER_ERR_TAG_EN
                    push_ent.err  = {1'b0, low_err};
`endif
                    state_nxt     = LOW;
                end
            end
            default: state_nxt = LOW;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            low_nib <= 4'h0;
`ifdef NIBBLE_PACKER_ERR_TAG_EN
            low_err <= 1'b0;
`endif
        end else if (state == LOW && in_valid) begin
            low_nib <= data_in;
`ifdef NIBBLE_PACKER_ERR_TAG_EN
            low_err <= syn_err;
`endif
        end
    end

    // ---------------- byte FIFO ----------------
    assign out_valid  = (level != '0);
    assign pop        = out_valid && out_ready;
    assign full       = (level == FULL_LVL);
    // A pop in the same cycle frees the slot the push needs.
    assign wr_en      = push && (!full || pop);
    assign fifo_level = level;
    assign out_byte   = mem[rd_ptr].data;
`ifdef NIBBLE_PACKER_ERR_TAG_EN
    assign out_err    = mem[rd_ptr].err;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (wr_en) begin
                mem[wr_ptr] <= push_ent;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            case ({wr_en, pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

    // ---------------- status ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)               overflow <= 1'b0;
        else if (push && !wr_en) overflow <= 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                                     err_count <= '0;
        else if (in_valid && syn_err && !(&err_count)) err_count <= err_count + CNT_W'(1);
    end

endmodule

// File: doc/nibble_packer.md
Name: nibble_packer

Overview:
- Downstream stage of the Hamming(7,4) decode stage. Consumes one corrected 4-bit data nibble and its 3-bit syndrome per valid cycle.
- Pairs consecutive nibbles into bytes: low nibble first, then high nibble.
- Buffers bytes in a small FIFO with a valid/ready output handshake.
- Keeps a saturating count of nibbles that needed correction (nonzero syndrome) and a sticky overflow flag.

Parameters:
- FIFO_DEPTH, 4, byte FIFO entries; power of two, at least 2.
- CNT_W, 16, width of the corrected-nibble counter.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst  input  1  asynchronous, active-low reset.
- in_valid  input  1  syndrome_in/data_in valid this cycle; aligned with the decode stage's registered outputs.
- syndrome_in  input  3  syndrome from the decode stage.
- data_in  input  4  corrected nibble from the decode stage.
- flush  input  1  force out a pending half-byte.
- out_valid  output  1  FIFO non-empty.
- out_ready  input  1  consumer accepts out_byte.
- out_byte  output  8  FIFO head byte.
- err_count  output  CNT_W  saturating count of nonzero syndromes.
- overflow  output  1  sticky: a byte was dropped because the FIFO was full.
- fifo_level  output  $clog2(FIFO_DEPTH)+1  current occupancy.

Behaviour:
- Reset (rst=0, async): state=LOW, FIFO empty, out_valid=0, out_byte=0, err_count=0, overflow=0, fifo_level=0. A reset mid-byte discards the pending low nibble.
- FSM, state LOW:
  - in_valid=1 → latch data_in into the low nibble and the low error flag (syndrome_in!=0); go to HIGH.
- FSM, state HIGH:
  - in_valid=1 → form byte {data_in, low}; request a push; go to LOW.
  - flush=1 with in_valid=0 → form byte {4'h0, low}; request a push; go to LOW.
  - flush=1 in LOW → no effect.
  - flush=1 and in_valid=1 in the same cycle while in HIGH → the nibble completes the byte normally; flush is ignored that cycle.
- Push/pop:
  - Pop occurs when out_valid && out_ready.
  - A push succeeds if the FIFO is not full, or if a pop happens in the same cycle.
  - Simultaneous push and pop leaves fifo_level unchanged.
  - Push while full with no pop → byte dropped; overflow set and held until reset; FSM still returns to LOW.
- Latency: a byte pushed at edge N has out_valid=1 and out_byte valid after edge N, i.e. one cycle after its second nibble is presented.
- Output stability: out_byte is a combinational read of the FIFO head and is stable while out_valid=1 and out_ready=0. out_byte=0 is not required when empty.
- Ordering: pointers wrap modulo FIFO_DEPTH; bytes leave in push order.
- err_count:
  - Increments by 1 on every in_valid cycle with syndrome_in!=0.
  - Counts in both LOW and HIGH, including nibbles whose byte is later dropped.
  - Saturates at 2^CNT_W-1; no wrap.
- No input backpressure: in_valid is always accepted.

Optional Feature:
- Macro NIBBLE_PACKER_ERR_TAG_EN.
- Defined:
  - Adds output port out_err (2 bits), widening each FIFO entry to 10 bits.
  - out_err[0] = low nibble had nonzero syndrome; out_err[1] = high nibble had nonzero syndrome.
  - A flushed byte has out_err[1]=0.
  - out_err follows out_byte timing exactly.
- Undefined: port absent; FIFO entries are 8 bits; all other behaviour identical.

Test Plan:
- Reset release, then in_valid nibbles 4'hA (syn 0) then 4'h5 (syn 0), out_ready=1 → out_valid pulses 1 cycle with out_byte=8'h5A; err_count=0.
- Nibbles 4'h3 (syn 3'b101) then 4'hC (syn 0), out_ready=0 → out_byte=8'hC3 held stable over 5 cycles; err_count=1; with the tag feature, out_err=2'b01.
- out_ready=0; push FIFO_DEPTH+1 bytes (8'h01..8'h05, default depth 4) → overflow=1, fifo_level=4; draining yields 8'h01..8'h04 in order; overflow stays 1.
- Full FIFO; push 8'h77 in the same cycle as a pop → push accepted; fifo_level stays 4; 8'h77 is last out.
- Nibble 4'h9 then flush=1 → out_byte=8'h09; next nibbles 4'h1, 4'h2 → 8'h21, with no misalignment.
- CNT_W=2: feed 5 nibbles with nonzero syndrome → err_count stops at 3. Assert rst low in HIGH → all outputs return to reset values immediately; next two nibbles form a fresh byte.
